// File: rtl/qformat_pkg.sv
// Shared Q-format sign-magnitude definitions: default widths, FSM encodings and
// the magnitude/pack helpers also used by the sequential multiplier.
package qformat_pkg;

    localparam int unsigned DefN = 16;
    localparam int unsigned DefQ = 8;

    // Helpers work on a wide container so any N up to MaxW can share them.
    localparam int unsigned MaxW = 64;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic logic [MaxW-1:0] sm_mag(
        input logic [MaxW-1:0] w,
        input int unsigned     n
    );
        return w & ((MaxW'(1) << (n - 1)) - MaxW'(1));
    endfunction

    // Clamp to the largest n-bit magnitude and drop the sign of a zero result.
    function automatic logic [MaxW-1:0] sm_pack_sat(
        input logic            sign,
        input logic [MaxW-1:0] mag,
        input logic            force_sat,
        input int unsigned     n
    );
        logic [MaxW-1:0] lim;
        logic [MaxW-1:0] m;
        logic            s;
        lim = (MaxW'(1) << (n - 1)) - MaxW'(1);
        m   = (force_sat || (mag > lim)) ? lim : mag;
        s   = (m != '0) && sign;
        return (MaxW'(s) << (n - 1)) | m;
    endfunction

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift in a numerator bit, subtract the divisor if it fits.
module qdiv_step #(
    parameter int unsigned MW = 15
) (
    input  logic [MW-1:0] i_rem,
    input  logic          i_bit,
    input  logic [MW-1:0] i_dvs,
    output logic [MW-1:0] o_rem,
    output logic          o_qbit
);

    logic [MW:0] w_shift;

    // The remainder stays below the divisor, so the result always fits back in MW bits.
    always_comb begin
        w_shift = {i_rem, i_bit};
        o_qbit  = (w_shift >= {1'b0, i_dvs});
        o_rem   = MW'(o_qbit ? (w_shift - {1'b0, i_dvs}) : w_shift);
    end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider, one quotient bit per clock,
// with saturation and divide-by-zero flagged through o_overflow.
module qdiv_seq
    import qformat_pkg::*;
#(
    parameter int unsigned N = DefN,
    parameter int unsigned Q = DefQ
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    input  logic         i_start,
    output logic [N-1:0] o_quotient_out,
    output logic         o_complete,
    output logic         o_overflow,
    output logic         o_busy
);

    localparam int unsigned D  = N - 1 + Q;
    localparam int unsigned CW = $clog2(D + 1);

    logic [1:0]   r_state;
    logic [D-1:0] r_num;
    logic [D-1:0] r_quot;
    logic [N-2:0] r_dvs;
    logic [N-2:0] r_rem;
    logic [CW-1:0] r_cnt;
    logic         r_sign;
    logic [N-1:0] r_quot_out;
    logic         r_complete;
    logic         r_overflow;

    logic [N-2:0] w_rem;
    logic         w_qbit;
    logic         w_sat;

    qdiv_step #(
        .MW(N - 1)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_num[D-1]),
        .i_dvs (r_dvs),
        .o_rem (w_rem),
        .o_qbit(w_qbit)
    );

    // Integer part wider than the magnitude field, or a zero divisor, saturates.
    assign w_sat = (r_dvs == '0) || (r_quot[D-1:N-1] != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_num      <= '0;
            r_quot     <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_quot_out <= '0;
            r_complete <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_num      <= D'(sm_mag(MaxW'(i_dividend), N) << Q);
                        r_dvs      <= (N-1)'(sm_mag(MaxW'(i_divisor), N));
                        r_sign     <= i_dividend[N-1] ^ i_divisor[N-1];
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_cnt      <= CW'(D);
                        r_complete <= 1'b0;
                        r_overflow <= 1'b0;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    if (r_cnt != '0) begin
                        r_rem  <= w_rem;
                        r_quot <= {r_quot[D-2:0], w_qbit};
                        r_num  <= {r_num[D-2:0], 1'b0};
                        r_cnt  <= r_cnt - CW'(1);
                    end else begin
                        // Final cycle packs the result so o_complete rises D+1 edges after start.
                        r_quot_out <= N'(sm_pack_sat(r_sign, MaxW'(r_quot), w_sat, N));
                        r_overflow <= w_sat;
                        r_complete <= 1'b1;
                        r_state    <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_quotient_out = r_quot_out;
    assign o_complete     = r_complete;
    assign o_overflow     = r_overflow;
    assign o_busy         = (r_state == StRun);

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed Q8.8 cases, handshake protocol, reset and random operands.
module tb_qdiv_seq;

    localparam int N = 16;
    localparam int Q = 8;
    localparam int D = N - 1 + Q;
    localparam int LAT = D + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [15:0] quo;
    logic        cmpl;
    logic        ovf;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    qdiv_seq #(
        .N(N),
        .Q(Q)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_dividend    (dvd),
        .i_divisor     (dvs),
        .i_start       (start),
        .o_quotient_out(quo),
        .o_complete    (cmpl),
        .o_overflow    (ovf),
        .o_busy        (busy)
    );

    // Reference: trunc((|a| << Q) / |b|), saturate to 0x7FFF, sign = xor unless magnitude is 0.
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic v);
        longint unsigned num;
        longint unsigned res;
        logic s;
        num = {49'd0, a[14:0]} << Q;
        if (b[14:0] == 15'd0) begin
            res = 64'h7FFF;
            v   = 1'b1;
        end else begin
            res = num / {49'd0, b[14:0]};
            v   = (res > 64'h7FFF);
            if (v) res = 64'h7FFF;
        end
        s = (res == 0) ? 1'b0 : (a[15] ^ b[15]);
        q = {s, res[14:0]};
    endfunction

    // Drive one start and wait for completion; hs_ok tracks busy/complete exclusivity.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic v,
                          output int lat, output logic hs_ok);
        dvd   = a;
        dvs   = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        hs_ok = 1'b1;
        while (!cmpl && lat < 60) begin
            if (busy !== 1'b1) hs_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b0) hs_ok = 1'b0;
        q = quo;
        v = ovf;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if ({quo, cmpl, ovf, busy} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got q=%h c=%b o=%b b=%b want all 0", quo, cmpl, ovf, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || cmpl !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b cmpl=%b want 0 0", busy, cmpl);
        end
    endtask

    task automatic test_directed();
        logic [15:0] tab_a [5] = '{16'h0300, 16'h8100, 16'h8001, 16'h7F00, 16'h0100};
        logic [15:0] tab_b [5] = '{16'h0200, 16'h0400, 16'h7F00, 16'h0080, 16'h0000};
        logic [15:0] tab_q [5] = '{16'h0180, 16'h8040, 16'h0000, 16'h7FFF, 16'h7FFF};
        logic        tab_v [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] q;
        logic v, hs;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_div(tab_a[i], tab_b[i], q, v, lat, hs);
            n_cmp++;
            if (q !== tab_q[i] || v !== tab_v[i]) begin
                n_bad++;
                $display("FAIL directed_%0d: %h/%h got q=%h ovf=%b want q=%h ovf=%b",
                         i, tab_a[i], tab_b[i], q, v, tab_q[i], tab_v[i]);
            end
            n_cmp++;
            if (lat != LAT || hs !== 1'b1) begin
                n_bad++;
                $display("FAIL directed_lat_%0d: got lat=%0d hs=%b want lat=%0d hs=1", i, lat, hs, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q;
        logic v, hs;
        int lat;
        n_cmp++;
        if (cmpl !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_pre_done: got cmpl=%b want 1", cmpl);
        end
        do_div(16'h0100, 16'h0100, q, v, lat, hs);
        n_cmp++;
        if (q !== 16'h0100 || v !== 1'b0 || lat != LAT || hs !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b: got q=%h ovf=%b lat=%0d hs=%b want q=0100 ovf=0 lat=%0d hs=1",
                     q, v, lat, hs, LAT);
        end
    endtask

    task automatic test_start_during_run();
        int lat;
        dvd   = 16'h0300;
        dvs   = 16'h0200;
        start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!cmpl && lat < 60) begin
            start = (lat % 3 == 0);
            dvd   = 16'($urandom);
            dvs   = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_cmp++;
        if (quo !== 16'h0180 || ovf !== 1'b0 || lat != LAT) begin
            n_bad++;
            $display("FAIL start_during_run: got q=%h ovf=%b lat=%0d want q=0180 ovf=0 lat=%0d",
                     quo, ovf, lat, LAT);
        end
    endtask

    task automatic test_reset_midway();
        logic seen;
        dvd   = 16'h0500;
        dvs   = 16'h0300;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({quo, cmpl, ovf, busy} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_midway: got q=%h c=%b o=%b b=%b want all 0", quo, cmpl, ovf, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (cmpl !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midway_quiet: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_reset_with_start();
        logic seen;
        dvd   = 16'h0300;
        dvs   = 16'h0200;
        start = 1'b1;
        rst   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (cmpl !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_with_start: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, q, eq;
        logic v, ev, hs;
        int lat;
        for (int i = 0; i < 240; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 8 == 0) b[14:0] = 15'($urandom_range(0, 3));
            else if (i % 8 == 1) b[14:0] = 15'($urandom_range(1, 255));
            a[15] = i[0];
            b[15] = i[1];
            ref_div(a, b, eq, ev);
            do_div(a, b, q, v, lat, hs);
            n_cmp++;
            if (q !== eq || v !== ev) begin
                n_bad++;
                $display("FAIL random_%0d: %h/%h got q=%h ovf=%b want q=%h ovf=%b",
                         i, a, b, q, v, eq, ev);
            end
            n_cmp++;
            if (lat != LAT || hs !== 1'b1) begin
                n_bad++;
                $display("FAIL random_lat_%0d: got lat=%0d hs=%b want lat=%0d hs=1", i, lat, hs, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_during_run();
        test_reset_midway();
        test_reset_with_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
